// File: rtl/step_grid_plotter.sv
// step_grid_plotter
//   Pixel-write engine for the step-sequencer display. Renders a TRACKS x STEPS
//   grid of cells as a stream of pixel writes, one per clock. A full redraw runs
//   after reset and on start. With AUTO=1, idle input changes trigger a redraw
//   of only the columns whose pattern bits or playhead state changed.
//
//   Ports
//     CLOCK_50   in   system clock
//     reset      in   asynchronous active-high reset
//     pattern    in   step bits, bit t*STEPS+s = track t, step s
//     playhead   in   current step (>= STEPS highlights no column)
//     start      in   full-redraw request (pulse or level)
//     VGA_X      out  pixel x
//     VGA_Y      out  pixel y
//     VGA_COLOR  out  pixel colour
//     plot       out  pixel write strobe
//     busy       out  pass in progress (SETUP/DRAW/SKIP)
//     done       out  one-cycle pulse after the last column of a pass
//
//   state | meaning
//   IDLE  | wait for start/pending full redraw or (AUTO) input change
//   SETUP | clear scan counters, pick DRAW or SKIP for column 0
//   DRAW  | emit one pixel per cycle of a dirty column
//   SKIP  | one idle cycle for a clean column
//   FIN   | pulse done, record what is now on screen

module step_grid_plotter #(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int COLOR_DEPTH = 9,
  parameter int TRACKS      = 4,
  parameter int STEPS       = 16,
  parameter int CELL_W      = 32,
  parameter int CELL_H      = 32,
  parameter int GAP         = 2,
  parameter int X0          = 64,
  parameter int Y0          = 96,
  parameter int AUTO        = 1,
  parameter logic [COLOR_DEPTH-1:0] COL_GRID = '0,
  parameter logic [COLOR_DEPTH-1:0] COL_OFF  = COLOR_DEPTH'(9'h049),
  parameter logic [COLOR_DEPTH-1:0] COL_ON   = COLOR_DEPTH'(9'h1C0),
  parameter logic [COLOR_DEPTH-1:0] COL_PLAY = COLOR_DEPTH'(9'h007),
  parameter logic [COLOR_DEPTH-1:0] COL_HIT  = COLOR_DEPTH'(9'h1FF),
  parameter int PW          = $clog2(STEPS)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [TRACKS*STEPS-1:0]  pattern,
  input  logic [PW-1:0]            playhead,
  input  logic                     start,
  output logic [XW-1:0]            VGA_X,
  output logic [YW-1:0]            VGA_Y,
  output logic [COLOR_DEPTH-1:0]   VGA_COLOR,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  localparam int NB  = TRACKS * STEPS;
  localparam int CW  = (STEPS  > 1) ? $clog2(STEPS)  : 1;
  localparam int RW  = (TRACKS > 1) ? $clog2(TRACKS) : 1;
  localparam int PXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int PYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  // Playhead registers must be able to hold STEPS ("no column") even when
  // the input port is too narrow to express it.
  localparam int PHW = ($clog2(STEPS + 1) > PW) ? $clog2(STEPS + 1) : PW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_DRAW  = 3'd2;
  localparam logic [2:0] S_SKIP  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  if (X0 + STEPS * CELL_W > (1 << XW)) begin : g_err_x
    $error("step_grid_plotter: grid exceeds horizontal resolution");
  end
  if (Y0 + TRACKS * CELL_H > (1 << YW)) begin : g_err_y
    $error("step_grid_plotter: grid exceeds vertical resolution");
  end
  if (GAP >= CELL_W || GAP >= CELL_H) begin : g_err_gap
    $error("step_grid_plotter: GAP must be smaller than the cell");
  end

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    col_q, col_d, col_nxt;
  logic [RW-1:0]    row_q, row_d;
  logic [PXW-1:0]   px_q, px_d;
  logic [PYW-1:0]   py_q, py_d;
  logic [STEPS-1:0] mask_q, mask_d, diff_mask;
  logic [NB-1:0]    work_pat_q, work_pat_d, drawn_pat_q, drawn_pat_d;
  logic [PHW-1:0]   work_ph_q, work_ph_d, drawn_ph_q, drawn_ph_d, ph_live;
  logic             full_pend_q, full_pend_d;
  logic             launch, adv, col_last, pix_last;

  logic [XW-1:0]          pix_x;
  logic [YW-1:0]          pix_y;
  logic [COLOR_DEPTH-1:0] pix_c;
  logic [IW-1:0]          pix_idx;
  logic                   cell_bit, cell_ph, cell_grid;

  assign ph_live  = PHW'(playhead);
  assign col_nxt  = col_q + CW'(1);
  assign col_last = (col_q == CW'(STEPS - 1));
  assign pix_last = (px_q == PXW'(CELL_W - 1)) && (py_q == PYW'(CELL_H - 1)) &&
                    (row_q == RW'(TRACKS - 1));

  // A column is dirty if any of its track bits changed, or it held or will
  // hold the playhead highlight.
  always_comb begin
    diff_mask = '0;
    for (int s = 0; s < STEPS; s++) begin
      for (int t = 0; t < TRACKS; t++) begin
        if (pattern[t*STEPS+s] != drawn_pat_q[t*STEPS+s]) diff_mask[s] = 1'b1;
      end
      if (PHW'(s) == drawn_ph_q || PHW'(s) == ph_live) diff_mask[s] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    px_d        = px_q;
    py_d        = py_q;
    mask_d      = mask_q;
    work_pat_d  = work_pat_q;
    work_ph_d   = work_ph_q;
    drawn_pat_d = drawn_pat_q;
    drawn_ph_d  = drawn_ph_q;
    full_pend_d = full_pend_q | start;
    launch      = 1'b0;
    adv         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start || full_pend_q) begin
          mask_d      = '1;
          full_pend_d = 1'b0;
          launch      = 1'b1;
        end else if (AUTO != 0 && (pattern != drawn_pat_q || ph_live != drawn_ph_q)) begin
          mask_d = diff_mask;
          launch = 1'b1;
        end
        if (launch) begin
          work_pat_d = pattern;
          work_ph_d  = ph_live;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        col_d   = '0;
        row_d   = '0;
        px_d    = '0;
        py_d    = '0;
        state_d = mask_q[0] ? S_DRAW : S_SKIP;
      end
      S_DRAW: begin
        if (pix_last) begin
          adv = 1'b1;
        end else if (px_q != PXW'(CELL_W - 1)) begin
          px_d = px_q + PXW'(1);
        end else begin
          px_d = '0;
          if (py_q != PYW'(CELL_H - 1)) begin
            py_d = py_q + PYW'(1);
          end else begin
            py_d  = '0;
            row_d = row_q + RW'(1);
          end
        end
      end
      S_SKIP: adv = 1'b1;
      S_FIN: begin
        drawn_pat_d = work_pat_q;
        drawn_ph_d  = work_ph_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (col_last) begin
        state_d = S_FIN;
      end else begin
        col_d   = col_nxt;
        row_d   = '0;
        px_d    = '0;
        py_d    = '0;
        state_d = mask_q[col_nxt] ? S_DRAW : S_SKIP;
      end
    end
  end

  // Pixel for the next cycle, built from next-state counters so the
  // registered outputs line up with the DRAW cycle that owns them.
  always_comb begin
    pix_x     = XW'(X0) + XW'(col_d) * XW'(CELL_W) + XW'(px_d);
    pix_y     = YW'(Y0) + YW'(row_d) * YW'(CELL_H) + YW'(py_d);
    pix_idx   = IW'(row_d) * IW'(STEPS) + IW'(col_d);
    cell_bit  = work_pat_q[pix_idx];
    cell_ph   = (PHW'(col_d) == work_ph_q);
    cell_grid = (GAP > 0) && ((px_d >= PXW'(CELL_W - GAP)) || (py_d >= PYW'(CELL_H - GAP)));
    if (cell_grid)                 pix_c = COL_GRID;
    else if (cell_bit && cell_ph)  pix_c = COL_HIT;
    else if (cell_bit)             pix_c = COL_ON;
    else if (cell_ph)              pix_c = COL_PLAY;
    else                           pix_c = COL_OFF;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      mask_q      <= '0;
      work_pat_q  <= '0;
      work_ph_q   <= '0;
      drawn_pat_q <= '0;
      drawn_ph_q  <= PHW'(STEPS);
      full_pend_q <= 1'b1;
      VGA_X       <= '0;
      VGA_Y       <= '0;
      VGA_COLOR   <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      px_q        <= px_d;
      py_q        <= py_d;
      mask_q      <= mask_d;
      work_pat_q  <= work_pat_d;
      work_ph_q   <= work_ph_d;
      drawn_pat_q <= drawn_pat_d;
      drawn_ph_q  <= drawn_ph_d;
      full_pend_q <= full_pend_d;
      plot        <= (state_d == S_DRAW);
      busy        <= (state_d == S_SETUP) || (state_d == S_DRAW) || (state_d == S_SKIP);
      done        <= (state_d == S_FIN);
      if (state_d == S_DRAW) begin
        VGA_X     <= pix_x;
        VGA_Y     <= pix_y;
        VGA_COLOR <= pix_c;
      end
    end
  end

endmodule

// File: tb/tb_step_grid_plotter.sv
module tb_step_grid_plotter;

  localparam int TR = 2, ST = 4, CWD = 4, CHT = 3, GP = 1, XO = 10, YO = 20;
  localparam logic [8:0] C_GRID = 9'h000, C_OFF = 9'h049, C_ON = 9'h1C0,
                         C_PLAY = 9'h007, C_HIT = 9'h1FF;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst2, start1, start2;
  logic [7:0] pat1, pat2;
  logic [2:0] ph1, ph2;
  logic [9:0] x1, x2;
  logic [8:0] y1, y2, c1, c2;
  logic       plot1, plot2, busy1, busy2, done1, done2;

  step_grid_plotter #(.TRACKS(TR), .STEPS(ST), .CELL_W(CWD), .CELL_H(CHT), .GAP(GP),
                      .X0(XO), .Y0(YO), .AUTO(1), .PW(3)) dut (
    .CLOCK_50(clk), .reset(rst1), .pattern(pat1), .playhead(ph1), .start(start1),
    .VGA_X(x1), .VGA_Y(y1), .VGA_COLOR(c1), .plot(plot1), .busy(busy1), .done(done1));

  step_grid_plotter #(.TRACKS(TR), .STEPS(ST), .CELL_W(CWD), .CELL_H(CHT), .GAP(GP),
                      .X0(XO), .Y0(YO), .AUTO(0), .PW(3)) dut_manual (
    .CLOCK_50(clk), .reset(rst2), .pattern(pat2), .playhead(ph2), .start(start2),
    .VGA_X(x2), .VGA_Y(y2), .VGA_COLOR(c2), .plot(plot2), .busy(busy2), .done(done2));

  // observed word: {busy, done, plot, x[9:0], y[8:0], colour[8:0]}
  logic        sel;
  logic [30:0] obs;
  assign obs = sel ? {busy2, done2, plot2, x2, y2, c2} : {busy1, done1, plot1, x1, y1, c1};

  int errors = 0;
  int checks = 0;

  // model: what the bench believes is on screen, and the held output values
  logic [7:0] m_pat;
  int         m_ph;
  logic [9:0] hx;
  logic [8:0] hy, hc;

  task automatic chk(input string tag, input logic [30:0] got, input logic [30:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_color(input int col, input int row, input int px,
                                           input int py, input logic [7:0] pat, input int ph);
    logic b;
    logic p;
    if (px >= CWD - GP || py >= CHT - GP) return C_GRID;
    b = pat[row*ST+col];
    p = (col == ph);
    if (b && p) return C_HIT;
    if (b)      return C_ON;
    if (p)      return C_PLAY;
    return C_OFF;
  endfunction

  function automatic logic [3:0] mask_for(input logic [7:0] np, input int nph);
    logic [3:0] m;
    m = '0;
    for (int s = 0; s < ST; s++) begin
      for (int t = 0; t < TR; t++)
        if (np[t*ST+s] !== m_pat[t*ST+s]) m[s] = 1'b1;
      if (s == m_ph || s == nph) m[s] = 1'b1;
    end
    return m;
  endfunction

  task automatic run_pass(input string tag, input logic [3:0] mask, input logic [7:0] wpat,
                          input int wph, input int wait_max, input bit kick,
                          input int inj, input logic [7:0] inj_pat);
    logic [30:0] q[$];
    logic [30:0] setup_exp;
    int          nplot, exp_plots;
    bit          got;
    setup_exp = {3'b100, hx, hy, hc};
    exp_plots = 0;
    for (int col = 0; col < ST; col++) begin
      if (mask[col]) begin
        for (int row = 0; row < TR; row++)
          for (int py = 0; py < CHT; py++)
            for (int px = 0; px < CWD; px++) begin
              hx = 10'(XO + col*CWD + px);
              hy = 9'(YO + row*CHT + py);
              hc = exp_color(col, row, px, py, wpat, wph);
              q.push_back({3'b101, hx, hy, hc});
              exp_plots++;
            end
      end else begin
        q.push_back({3'b100, hx, hy, hc});
      end
    end
    if (kick) begin
      if (sel) start2 = 1'b1; else start1 = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < wait_max; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      if (obs[30]) begin got = 1'b1; break; end
    end
    chk({tag, "_begin"}, {30'b0, got}, 31'd1);
    if (!got) return;
    chk({tag, "_setup"}, obs, setup_exp);
    nplot = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk(tag, obs, q[i]);
      if (obs[28]) nplot++;
      if (i == inj) begin
        start1 = 1'b1;
        pat1   = inj_pat;
      end else if (i == inj + 1) begin
        start1 = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_fin"}, obs, {3'b010, hx, hy, hc});
    @(negedge clk);
    chk({tag, "_idle"}, obs, {3'b000, hx, hy, hc});
    chk({tag, "_plots"}, 31'(nplot), 31'(exp_plots));
    m_pat = wpat;
    m_ph  = wph;
  endtask

  initial begin
    logic [7:0] np, ip;
    int         nph, n;
    sel = 1'b0;
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    pat1 = 8'h00; pat2 = 8'h00; ph1 = 3'd4; ph2 = 3'd4;
    m_pat = 8'h00; m_ph = ST; hx = '0; hy = '0; hc = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", obs, 31'b0);

    // power-up full redraw
    rst1 = 1'b0;
    run_pass("powerup", 4'hF, pat1, ph1, 5, 1'b0, -1, 8'h00);

    // single step set: only column 2 redrawn
    pat1 = 8'b0000_0100;
    run_pass("step_t0s2", mask_for(pat1, ph1), pat1, ph1, 5, 1'b0, -1, 8'h00);

    // playhead moves
    ph1 = 3'd1;
    run_pass("ph_4to1", mask_for(pat1, ph1), pat1, ph1, 5, 1'b0, -1, 8'h00);
    ph1 = 3'd2;
    run_pass("ph_1to2", mask_for(pat1, ph1), pat1, ph1, 5, 1'b0, -1, 8'h00);

    // random incremental updates
    for (int k = 0; k < 6; k++) begin
      np  = 8'($urandom);
      nph = $urandom_range(0, 4);
      if (np == m_pat && nph == m_ph) np = m_pat ^ 8'h01;
      pat1 = np;
      ph1  = 3'(nph);
      run_pass("rand_auto", mask_for(np, nph), np, nph, 5, 1'b0, -1, 8'h00);
    end

    // start pulse mid-pass queues a full pass right after done
    np = m_pat ^ 8'(($urandom_range(1, 255)));
    ip = 8'($urandom);
    pat1 = np;
    run_pass("pre_start", mask_for(np, m_ph), np, m_ph, 5, 1'b0, 10, ip);
    run_pass("queued_full", 4'hF, ip, m_ph, 1, 1'b0, -1, 8'h00);

    // reset in the middle of a full pass
    start1 = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (plot1) n++;
      if (n == 40) break;
    end
    chk("reached_pixel40", 31'(n), 31'd40);
    rst1 = 1'b1;
    #1;
    chk("async_reset_abort", obs, 31'b0);
    repeat (2) @(negedge clk);
    chk("reset_hold", obs, 31'b0);
    rst1 = 1'b0;
    m_pat = 8'h00; m_ph = ST; hx = '0; hy = '0; hc = '0;
    run_pass("after_reset", 4'hF, pat1, ph1, 5, 1'b0, -1, 8'h00);

    // AUTO=0 instance: changes alone never draw
    sel = 1'b1;
    hx = '0; hy = '0; hc = '0;
    rst2 = 1'b0;
    run_pass("manual_powerup", 4'hF, pat2, ph2, 5, 1'b0, -1, 8'h00);
    pat2 = 8'($urandom_range(1, 255));
    ph2  = 3'($urandom_range(0, 3));
    repeat (30) begin
      @(negedge clk);
      chk("manual_no_auto", obs, {3'b000, hx, hy, hc});
    end
    run_pass("manual_start", 4'hF, pat2, ph2, 3, 1'b1, -1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
